// File: rtl/op_scheduler.sv
// ============================================================================
// Module   : op_scheduler
// Brief    : Instruction FIFO plus issue sequencer for the FHE op controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_scheduler #(
  parameter int ADDR_WIDTH     = 9,
  parameter int QUEUE_DEPTH    = 4,
  parameter int PTR_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_valid,
  input  logic [31:0]           push_data,
  output logic                  push_ready,
  input  logic                  flush,
  input  logic                  clear_status,
  output logic                  issue_valid,
  output logic [1:0]            issue_opcode,
  output logic [ADDR_WIDTH-1:0] issue_op1_addr,
  output logic [ADDR_WIDTH-1:0] issue_op2_addr,
  output logic [ADDR_WIDTH-1:0] issue_out_addr,
  input  logic                  ctl_done,
  output logic                  busy,
  output logic [PTR_WIDTH:0]    queue_count,
  output logic                  overflow,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  ops_completed,
  output logic                  irq_done
);

  localparam int c_entry_w = 2 + 3 * ADDR_WIDTH;
  localparam int c_wd_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PTR_WIDTH:0]   c_full    = (PTR_WIDTH + 1)'(QUEUE_DEPTH);
  localparam logic [PTR_WIDTH:0]   c_cnt_one = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH-1:0] c_ptr_one = PTR_WIDTH'(1);
  localparam logic [c_wd_w-1:0]    c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [c_entry_w-1:0]   r_mem [QUEUE_DEPTH];
  logic [PTR_WIDTH-1:0]   r_wr_ptr;
  logic [PTR_WIDTH-1:0]   r_rd_ptr;
  logic [PTR_WIDTH:0]     r_count;
  logic [c_wd_w-1:0]      r_wdog;
  logic                   r_issue_valid;
  logic [1:0]             r_opcode;
  logic [ADDR_WIDTH-1:0]  r_op1;
  logic [ADDR_WIDTH-1:0]  r_op2;
  logic [ADDR_WIDTH-1:0]  r_out;
  logic                   r_overflow;
  logic                   r_timeout;
  logic [CNT_WIDTH-1:0]   r_ops;
  logic                   r_irq;

  logic                   w_push_ok;
  logic                   w_ovf_set;
  logic                   w_pop;
  logic [PTR_WIDTH:0]     w_count_nxt;
  logic [c_entry_w-1:0]   w_head;

  assign push_ready = (r_count != c_full);
  assign w_push_ok  = push_valid && push_data[31] && push_ready && !flush;
  assign w_ovf_set  = push_valid && push_data[31] && !push_ready && !flush;
  assign w_pop      = (r_state == ST_ISSUE);

  // With an empty queue the only candidate head is the word arriving this edge.
  assign w_head = (r_count == '0) ? push_data[c_entry_w-1:0] : r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    if (flush)
      w_count_nxt = '0;
    else if (w_push_ok && !w_pop)
      w_count_nxt = r_count + c_cnt_one;
    else if (!w_push_ok && w_pop)
      w_count_nxt = r_count - c_cnt_one;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      for (int i = 0; i < QUEUE_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_wdog        <= '0;
      r_issue_valid <= 1'b0;
      r_opcode      <= '0;
      r_op1         <= '0;
      r_op2         <= '0;
      r_out         <= '0;
      r_overflow    <= 1'b0;
      r_timeout     <= 1'b0;
      r_ops         <= '0;
      r_irq         <= 1'b0;
    end else begin
      r_issue_valid <= 1'b0;
      r_irq         <= 1'b0;

      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= push_data[c_entry_w-1:0];
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end
      r_count <= w_count_nxt;

      if (clear_status) begin
        r_overflow <= 1'b0;
        r_timeout  <= 1'b0;
      end
      if (w_ovf_set) r_overflow <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (r_count != '0 && !flush) begin
            r_issue_valid <= 1'b1;
            r_opcode      <= w_head[1:0];
            r_op1         <= w_head[2 +: ADDR_WIDTH];
            r_op2         <= w_head[2 + ADDR_WIDTH +: ADDR_WIDTH];
            r_out         <= w_head[2 + 2 * ADDR_WIDTH +: ADDR_WIDTH];
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wdog  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ctl_done) begin
            r_ops <= r_ops + CNT_WIDTH'(1);
            if (w_count_nxt != '0) begin
              r_issue_valid <= 1'b1;
              r_opcode      <= w_head[1:0];
              r_op1         <= w_head[2 +: ADDR_WIDTH];
              r_op2         <= w_head[2 + ADDR_WIDTH +: ADDR_WIDTH];
              r_out         <= w_head[2 + 2 * ADDR_WIDTH +: ADDR_WIDTH];
              r_state       <= ST_ISSUE;
            end else begin
              r_irq   <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else if (r_wdog == c_wd_last) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + c_wd_w'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign issue_valid    = r_issue_valid;
  assign issue_opcode   = r_opcode;
  assign issue_op1_addr = r_op1;
  assign issue_op2_addr = r_op2;
  assign issue_out_addr = r_out;
  assign busy           = (r_state != ST_IDLE) || (r_count != '0);
  assign queue_count    = r_count;
  assign overflow       = r_overflow;
  assign timeout        = r_timeout;
  assign ops_completed  = r_ops;
  assign irq_done       = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_op_scheduler.sv
// ============================================================================
// Module   : tb_op_scheduler
// Brief    : Directed self-checking bench for op_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_op_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_data = '0;
  logic        flush = 1'b0;
  logic        clear_status = 1'b0;
  logic        ctl_done = 1'b0;

  logic        push_ready, issue_valid, busy, overflow, timeout, irq_done;
  logic [1:0]  issue_opcode;
  logic [8:0]  issue_op1_addr, issue_op2_addr, issue_out_addr;
  logic [2:0]  queue_count;
  logic [15:0] ops_completed;

  logic        wd_push_ready, wd_issue_valid, wd_busy, wd_overflow, wd_timeout, wd_irq_done;
  logic [1:0]  wd_issue_opcode;
  logic [8:0]  wd_issue_op1_addr, wd_issue_op2_addr, wd_issue_out_addr;
  logic [2:0]  wd_queue_count;
  logic [15:0] wd_ops_completed;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  op_scheduler #(.TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .flush(flush), .clear_status(clear_status),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_op1_addr(issue_op1_addr), .issue_op2_addr(issue_op2_addr),
    .issue_out_addr(issue_out_addr), .ctl_done(ctl_done), .busy(busy),
    .queue_count(queue_count), .overflow(overflow), .timeout(timeout),
    .ops_completed(ops_completed), .irq_done(irq_done)
  );

  op_scheduler #(.TIMEOUT_CYCLES(8)) dut_wd (
    .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_data(push_data),
    .push_ready(wd_push_ready), .flush(flush), .clear_status(clear_status),
    .issue_valid(wd_issue_valid), .issue_opcode(wd_issue_opcode),
    .issue_op1_addr(wd_issue_op1_addr), .issue_op2_addr(wd_issue_op2_addr),
    .issue_out_addr(wd_issue_out_addr), .ctl_done(ctl_done), .busy(wd_busy),
    .queue_count(wd_queue_count), .overflow(wd_overflow), .timeout(wd_timeout),
    .ops_completed(wd_ops_completed), .irq_done(wd_irq_done)
  );

  // {valid, 2'b0, out, op2, op1, opcode}
  function automatic logic [31:0] mkword(input logic [1:0] opc, input logic [8:0] a1,
                                         input logic [8:0] a2, input logic [8:0] ao,
                                         input logic v);
    return {v, 2'b00, ao, a2, a1, opc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; push_valid = 1'b0; push_data = '0; flush = 1'b0;
    clear_status = 1'b0; ctl_done = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (queue_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", queue_count); end
    checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", push_ready); end
    checks++; if ({issue_valid, issue_opcode, issue_op1_addr, issue_op2_addr, issue_out_addr} !== 30'd0) begin failures++; $display("FAIL rst_issue got=%0h exp=0", {issue_valid, issue_opcode, issue_op1_addr, issue_op2_addr, issue_out_addr}); end
    checks++; if ({busy, overflow, timeout, irq_done} !== 4'd0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {busy, overflow, timeout, irq_done}); end
    checks++; if (ops_completed !== 16'd0) begin failures++; $display("FAIL rst_ops got=%0d exp=0", ops_completed); end
  endtask

  task automatic test_single_issue();
    int pulses = 0;
    int irqs = 0;
    do_reset();
    push_valid = 1'b1; push_data = mkword(2'd2, 9'd1, 9'd2, 9'd0, 1'b1);
    step();                                   // E0: stored
    push_valid = 1'b0;
    checks++; if (queue_count !== 3'd1 || issue_valid !== 1'b0) begin failures++; $display("FAIL single_e0 got=cnt%0d iv%0b exp=cnt1 iv0", queue_count, issue_valid); end
    step();                                   // E1: ISSUE
    checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL single_iv got=%0b exp=1", issue_valid); end
    checks++; if ({issue_opcode, issue_op1_addr, issue_op2_addr, issue_out_addr} !== {2'd2, 9'd1, 9'd2, 9'd0}) begin failures++; $display("FAIL single_fields got=%0d/%0d/%0d/%0d exp=2/1/2/0", issue_opcode, issue_op1_addr, issue_op2_addr, issue_out_addr); end
    for (int i = 0; i < 9; i++) begin
      step();
      if (issue_valid) pulses++;
    end
    ctl_done = 1'b1;
    step();                                   // done sampled 10 cycles after issue
    ctl_done = 1'b0;
    if (irq_done) irqs++;
    checks++; if (ops_completed !== 16'd1) begin failures++; $display("FAIL single_ops got=%0d exp=1", ops_completed); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (irq_done) irqs++;
      if (issue_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL single_extra_issue got=%0d exp=0", pulses); end
    checks++; if (irqs !== 1) begin failures++; $display("FAIL single_irq got=%0d exp=1", irqs); end
    checks++; if (busy !== 1'b0 || queue_count !== 3'd0) begin failures++; $display("FAIL single_idle got=busy%0b cnt%0d exp=busy0 cnt0", busy, queue_count); end
  endtask

  task automatic test_fill_overflow();
    int issues = 0;
    do_reset();
    push_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_data = mkword(2'(i), 9'(i + 10), 9'(i + 20), 9'(i + 30), 1'b1);
      step();
      if (issue_valid) issues++;
    end
    checks++; if (queue_count !== 3'd4 || push_ready !== 1'b0) begin failures++; $display("FAIL fill_full got=cnt%0d rdy%0b exp=cnt4 rdy0", queue_count, push_ready); end
    checks++; if (overflow !== 1'b0 || issues !== 1) begin failures++; $display("FAIL fill_noovf got=ovf%0b iss%0d exp=ovf0 iss1", overflow, issues); end
    checks++; if (issue_op1_addr !== 9'd10) begin failures++; $display("FAIL fill_first got=%0d exp=10", issue_op1_addr); end
    push_data = mkword(2'd1, 9'd99, 9'd99, 9'd99, 1'b1);
    step();
    push_valid = 1'b0;
    checks++; if (overflow !== 1'b1 || queue_count !== 3'd4) begin failures++; $display("FAIL fill_ovf got=ovf%0b cnt%0d exp=ovf1 cnt4", overflow, queue_count); end
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_clear got=%0b exp=0", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    logic        prev_iv = 1'b0;
    int          n = 0;
    int          last = -1;
    int          irqs = 0;
    words[0] = mkword(2'd0, 9'd100, 9'd101, 9'd102, 1'b1);
    words[1] = mkword(2'd1, 9'd200, 9'd201, 9'd202, 1'b1);
    words[2] = mkword(2'd3, 9'd300, 9'd301, 9'd302, 1'b1);
    do_reset();
    push_valid = 1'b1; push_data = words[0];
    for (int c = 0; c < 14; c++) begin
      step();
      push_valid = (c < 2);
      if (c < 2) push_data = words[c + 1];
      if (irq_done) irqs++;
      if (issue_valid) begin
        if (n < 3) begin
          checks++; if ({issue_opcode, issue_op1_addr, issue_op2_addr, issue_out_addr} !== {words[n][1:0], words[n][10:2], words[n][19:11], words[n][28:20]}) begin failures++; $display("FAIL b2b_order%0d got=%0d/%0d exp=%0d/%0d", n, issue_opcode, issue_op1_addr, words[n][1:0], words[n][10:2]); end
        end
        if (last >= 0) begin
          checks++; if (c - last !== 2) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=2", n, c - last); end
        end
        last = c;
        n++;
      end
      ctl_done = prev_iv;                     // answer one cycle after each issue
      prev_iv  = issue_valid;
    end
    ctl_done = 1'b0;
    checks++; if (n !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n); end
    checks++; if (ops_completed !== 16'd3 || irqs !== 1) begin failures++; $display("FAIL b2b_done got=ops%0d irq%0d exp=ops3 irq1", ops_completed, irqs); end
  endtask

  task automatic test_watchdog();
    int irqs = 0;
    do_reset();
    push_valid = 1'b1; push_data = mkword(2'd1, 9'd7, 9'd8, 9'd9, 1'b1);
    step();                                   // E0
    push_data = mkword(2'd3, 9'd17, 9'd18, 9'd19, 1'b1);
    step();                                   // E1: ISSUE first op
    push_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin         // E2..E9
      step();
      if (wd_irq_done) irqs++;
    end
    checks++; if (wd_timeout !== 1'b0) begin failures++; $display("FAIL wd_early got=%0b exp=0", wd_timeout); end
    step();                                   // E10 = E2 + 8
    if (wd_irq_done) irqs++;
    checks++; if (wd_timeout !== 1'b1 || wd_ops_completed !== 16'd0) begin failures++; $display("FAIL wd_expire got=to%0b ops%0d exp=to1 ops0", wd_timeout, wd_ops_completed); end
    ctl_done = 1'b1;                          // arrives while IDLE
    step();                                   // E11
    ctl_done = 1'b0;
    if (wd_irq_done) irqs++;
    checks++; if (wd_issue_valid !== 1'b1 || wd_issue_op1_addr !== 9'd17) begin failures++; $display("FAIL wd_next got=iv%0b op1=%0d exp=iv1 op1=17", wd_issue_valid, wd_issue_op1_addr); end
    step();
    if (wd_irq_done) irqs++;
    checks++; if (wd_ops_completed !== 16'd0 || irqs !== 0) begin failures++; $display("FAIL wd_late got=ops%0d irq%0d exp=ops0 irq0", wd_ops_completed, irqs); end
  endtask

  task automatic test_flush();
    int irqs = 0;
    do_reset();
    push_valid = 1'b1; push_data = mkword(2'd2, 9'd40, 9'd41, 9'd42, 1'b1);
    step();                                   // E0
    push_data = mkword(2'd0, 9'd50, 9'd51, 9'd52, 1'b1);
    step();                                   // E1 ISSUE
    push_data = mkword(2'd1, 9'd60, 9'd61, 9'd62, 1'b1);
    step();                                   // E2 WAIT, two queued
    checks++; if (queue_count !== 3'd2) begin failures++; $display("FAIL flush_pre got=%0d exp=2", queue_count); end
    flush = 1'b1; push_data = mkword(2'd3, 9'd70, 9'd71, 9'd72, 1'b1);
    step();
    flush = 1'b0;
    checks++; if (queue_count !== 3'd0 || overflow !== 1'b0) begin failures++; $display("FAIL flush_empty got=cnt%0d ovf%0b exp=cnt0 ovf0", queue_count, overflow); end
    push_data = mkword(2'd3, 9'd80, 9'd81, 9'd82, 1'b0);
    step();
    push_valid = 1'b0;
    checks++; if (queue_count !== 3'd0 || overflow !== 1'b0) begin failures++; $display("FAIL flush_invalid got=cnt%0d ovf%0b exp=cnt0 ovf0", queue_count, overflow); end
    ctl_done = 1'b1;
    step();
    ctl_done = 1'b0;
    if (irq_done) irqs++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (irq_done) irqs++;
      checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL flush_noissue got=%0b exp=0", issue_valid); end
    end
    checks++; if (ops_completed !== 16'd1 || irqs !== 1 || busy !== 1'b0) begin failures++; $display("FAIL flush_done got=ops%0d irq%0d busy%0b exp=ops1 irq1 busy0", ops_completed, irqs, busy); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    push_valid = 1'b1; push_data = mkword(2'd3, 9'd5, 9'd6, 9'd7, 1'b1);
    step();
    push_valid = 1'b0;
    step(); step();                           // first op in WAIT
    ctl_done = 1'b1;
    push_valid = 1'b1; push_data = mkword(2'd3, 9'd11, 9'd12, 9'd13, 1'b1);
    step();                                   // completes, second op issues
    ctl_done = 1'b0;
    push_data = mkword(2'd1, 9'd21, 9'd22, 9'd23, 1'b1);
    step(); step();                           // second op in WAIT, third queued
    push_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (queue_count !== 3'd0 || busy !== 1'b0 || push_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_q got=cnt%0d busy%0b rdy%0b exp=cnt0 busy0 rdy1", queue_count, busy, push_ready); end
    checks++; if (ops_completed !== 16'd0 || {issue_opcode, issue_op1_addr} !== 11'd0) begin failures++; $display("FAIL mid_rst_regs got=ops%0d opc%0d op1=%0d exp=0", ops_completed, issue_opcode, issue_op1_addr); end
    step();
    rst_n = 1'b1;
    push_valid = 1'b1; push_data = mkword(2'd2, 9'd33, 9'd34, 9'd35, 1'b1);
    step();
    push_valid = 1'b0;
    step();
    checks++; if (issue_valid !== 1'b1 || issue_op1_addr !== 9'd33) begin failures++; $display("FAIL mid_rst_reissue got=iv%0b op1=%0d exp=iv1 op1=33", issue_valid, issue_op1_addr); end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_fill_overflow();
    test_back_to_back();
    test_watchdog();
    test_flush();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
